// File: rtl/controle_pkg.sv
// Purpose: shared state codes, opcode/funct constants and control-field encodings for the multicycle MIPS controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package controle_pkg;

    typedef enum logic [6:0] {
        FETCH   = 7'd0,
        DECODE  = 7'd1,
        EXEC_R  = 7'd2,
        WB_R    = 7'd3,
        EXEC_I  = 7'd4,
        WB_I    = 7'd5,
        ADDR    = 7'd6,
        LW_MEM  = 7'd7,
        LW_WB   = 7'd8,
        SW_MEM  = 7'd9,
        BRANCH  = 7'd10,
        JUMP    = 7'd11,
        EXC_OVF = 7'd12,
        EXC_OPC = 7'd13,
        EXC_MEM = 7'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;

    localparam logic [1:0] IORD_PC     = 2'b00;
    localparam logic [1:0] IORD_ALUOUT = 2'b01;
    localparam logic [1:0] IORD_VEC    = 2'b10;

    localparam logic [1:0] SRCA_PC = 2'b00;
    localparam logic [1:0] SRCA_A  = 2'b01;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] EXCP_CODE_OPC = 2'b01;
    localparam logic [1:0] EXCP_CODE_OVF = 2'b10;

    localparam logic [2:0] REGDST_RT = 3'b000;
    localparam logic [2:0] REGDST_RD = 3'b001;

    localparam logic [2:0] PCSRC_ALU    = 3'b000;
    localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_VEC    = 3'b011;

    localparam logic [3:0] DSRC_ALUOUT = 4'b0000;
    localparam logic [3:0] DSRC_MDR    = 4'b0001;

    // R-type funct to ALU operation; anything unrecognised just passes A.
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_PASSA;
        endcase
    endfunction

endpackage

// File: rtl/controle_decode.sv
// Purpose: maps OpCode/funct to the state that follows DECODE, and flags legal instructions.
// Latency: purely combinational.
// Backpressure: none; every input pattern yields an answer.
// Ports: OpCode, funct in; dispatch (next state for legal ops), legal out.
module controle_decode
    import controle_pkg::*;
(
    input  logic [5:0] OpCode,
    input  logic [5:0] funct,
    output state_t     dispatch,
    output logic       legal
);

    always_comb begin
        dispatch = FETCH;
        legal    = 1'b1;
        case (OpCode)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
                    dispatch = EXEC_R;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_ADDI, OP_ADDIU: dispatch = EXEC_I;
            OP_LW, OP_SW:      dispatch = ADDR;
            OP_BEQ, OP_BNE:    dispatch = BRANCH;
            OP_J:              dispatch = JUMP;
            default:           legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Purpose: multicycle MIPS control FSM (R-type, ADDI/ADDIU, LW/SW, BEQ/BNE, J, overflow and invalid-opcode traps).
// Latency: FETCH, LW_MEM and EXC_MEM each last MEM_WAIT+1 cycles; every other state lasts one cycle.
// Backpressure: none; memory is assumed ready after MEM_WAIT cycles, and unknown inputs always trap rather than stall.
// Ports: clk, reset (sync, active-high); OpCode/funct from IR; Zero/Overflow from ALU;
//        datapath enables and mux selects out; estado = current state code for debug.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int         MEM_WAIT = 2,
    parameter logic [7:0] VEC_OPC  = 8'd253,
    parameter logic [7:0] VEC_OVF  = 8'd254
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       MemCtrl,
    output logic       IRWrite,
    output logic       A_Control,
    output logic       B_Control,
    output logic       RegControl,
    output logic       ALUOutControl,
    output logic       EPCWrite,
    output logic [1:0] IorD,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ExcpCtrl,
    output logic [2:0] RegDst,
    output logic [2:0] PCSource,
    output logic [2:0] ALUControl,
    output logic [3:0] DataSrc,
    output logic [6:0] estado
);

    localparam int             CW       = $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0]  WAIT_MAX = CW'(MEM_WAIT);

    // The vectors are applied by the datapath via ExcpCtrl; they must differ for the two traps to be distinguishable.
    generate
        if (MEM_WAIT < 1 || VEC_OPC == VEC_OVF) begin : g_bad_params
            $error("controle_multiciclo: MEM_WAIT must be >= 1 and exception vectors must differ");
        end
    endgenerate

    state_t        state, state_next, dispatch;
    logic          legal;
    logic [CW-1:0] cnt;
    logic [1:0]    excp_q;
    logic          wait_done;
    logic          is_addsub;

    controle_decode u_decode (
        .OpCode   (OpCode),
        .funct    (funct),
        .dispatch (dispatch),
        .legal    (legal)
    );

    assign wait_done = (cnt == WAIT_MAX);
    assign is_addsub = (funct == FN_ADD) || (funct == FN_SUB);
    assign estado    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            cnt    <= '0;
            excp_q <= '0;
        end else begin
            state <= state_next;
            // Any state change restarts the count, so each memory phase begins at zero.
            if (state_next != state) begin
                cnt <= '0;
            end else if (!wait_done) begin
                cnt <= cnt + 1'b1;
            end
            if (state == EXC_OVF) begin
                excp_q <= EXCP_CODE_OVF;
            end else if (state == EXC_OPC) begin
                excp_q <= EXCP_CODE_OPC;
            end
        end
    end

    always_comb begin
        state_next    = FETCH;
        PCWrite       = 1'b0;
        MemCtrl       = 1'b0;
        IRWrite       = 1'b0;
        A_Control     = 1'b0;
        B_Control     = 1'b0;
        RegControl    = 1'b0;
        ALUOutControl = 1'b0;
        EPCWrite      = 1'b0;
        IorD          = IORD_PC;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_B;
        ExcpCtrl      = 2'b00;
        RegDst        = REGDST_RT;
        PCSource      = PCSRC_ALU;
        ALUControl    = ALU_PASSA;
        DataSrc       = DSRC_ALUOUT;
        case (state)
            FETCH: begin
                state_next = FETCH;
                if (wait_done) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    ALUSrcB    = SRCB_FOUR;
                    ALUControl = ALU_ADD;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                // Branch target is computed speculatively while registers are read.
                A_Control     = 1'b1;
                B_Control     = 1'b1;
                ALUOutControl = 1'b1;
                ALUSrcB       = SRCB_IMM_SH;
                ALUControl    = ALU_ADD;
                state_next    = legal ? dispatch : EXC_OPC;
            end
            EXEC_R: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ALUControl = funct_alu(funct);
                if (Overflow && is_addsub) begin
                    state_next = EXC_OVF;
                end else begin
                    ALUOutControl = 1'b1;
                    state_next    = WB_R;
                end
            end
            WB_R: begin
                RegControl = 1'b1;
                RegDst     = REGDST_RD;
                DataSrc    = DSRC_ALUOUT;
            end
            EXEC_I: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                // ADDIU never traps.
                if (Overflow && OpCode == OP_ADDI) begin
                    state_next = EXC_OVF;
                end else begin
                    ALUOutControl = 1'b1;
                    state_next    = WB_I;
                end
            end
            WB_I: begin
                RegControl = 1'b1;
                RegDst     = REGDST_RT;
            end
            ADDR: begin
                ALUSrcA       = SRCA_A;
                ALUSrcB       = SRCB_IMM;
                ALUControl    = ALU_ADD;
                ALUOutControl = 1'b1;
                state_next    = (OpCode == OP_SW) ? SW_MEM : LW_MEM;
            end
            LW_MEM: begin
                IorD       = IORD_ALUOUT;
                state_next = wait_done ? LW_WB : LW_MEM;
            end
            LW_WB: begin
                RegControl = 1'b1;
                RegDst     = REGDST_RT;
                DataSrc    = DSRC_MDR;
            end
            SW_MEM: begin
                IorD    = IORD_ALUOUT;
                MemCtrl = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ALUControl = ALU_SUB;
                PCSource   = PCSRC_ALUOUT;
                PCWrite    = (OpCode == OP_BEQ) ? Zero : !Zero;
            end
            JUMP: begin
                PCSource = PCSRC_JUMP;
                PCWrite  = 1'b1;
            end
            EXC_OVF, EXC_OPC: begin
                // EPC gets PC-4, i.e. the address of the faulting instruction.
                EPCWrite   = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_SUB;
                ExcpCtrl   = (state == EXC_OVF) ? EXCP_CODE_OVF : EXCP_CODE_OPC;
                state_next = EXC_MEM;
            end
            EXC_MEM: begin
                IorD       = IORD_VEC;
                ExcpCtrl   = excp_q;
                state_next = EXC_MEM;
                if (wait_done) begin
                    PCSource   = PCSRC_VEC;
                    PCWrite    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

    typedef struct packed {
        logic       pc_write;
        logic       mem_ctrl;
        logic       ir_write;
        logic       a_ctl;
        logic       b_ctl;
        logic       reg_ctl;
        logic       aluout_ctl;
        logic       epc_write;
        logic [1:0] iord;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] excp;
        logic [2:0] reg_dst;
        logic [2:0] pc_src;
        logic [2:0] alu_ctl;
        logic [3:0] data_src;
        logic [6:0] estado;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] fn = '0;
    logic       zero = 1'b0;
    logic       ovf = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // index 0: MEM_WAIT=2 instance, index 1: MEM_WAIT=4 instance
    logic       pc_write [2];
    logic       mem_ctrl [2];
    logic       ir_write [2];
    logic       a_ctl [2];
    logic       b_ctl [2];
    logic       reg_ctl [2];
    logic       aluout_ctl [2];
    logic       epc_write [2];
    logic [1:0] iord [2];
    logic [1:0] src_a [2];
    logic [1:0] src_b [2];
    logic [1:0] excp [2];
    logic [2:0] reg_dst [2];
    logic [2:0] pc_src [2];
    logic [2:0] alu_ctl [2];
    logic [3:0] data_src [2];
    logic [6:0] estado [2];
    obs_t       obs [2];

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign obs[g] = {pc_write[g], mem_ctrl[g], ir_write[g], a_ctl[g], b_ctl[g], reg_ctl[g],
                         aluout_ctl[g], epc_write[g], iord[g], src_a[g], src_b[g], excp[g],
                         reg_dst[g], pc_src[g], alu_ctl[g], data_src[g], estado[g]};
    end

    controle_multiciclo #(.MEM_WAIT(2), .VEC_OPC(8'd253), .VEC_OVF(8'd254)) dut2 (
        .clk(clk), .reset(reset), .OpCode(op), .funct(fn), .Zero(zero), .Overflow(ovf),
        .PCWrite(pc_write[0]), .MemCtrl(mem_ctrl[0]), .IRWrite(ir_write[0]),
        .A_Control(a_ctl[0]), .B_Control(b_ctl[0]), .RegControl(reg_ctl[0]),
        .ALUOutControl(aluout_ctl[0]), .EPCWrite(epc_write[0]), .IorD(iord[0]),
        .ALUSrcA(src_a[0]), .ALUSrcB(src_b[0]), .ExcpCtrl(excp[0]), .RegDst(reg_dst[0]),
        .PCSource(pc_src[0]), .ALUControl(alu_ctl[0]), .DataSrc(data_src[0]), .estado(estado[0])
    );

    controle_multiciclo #(.MEM_WAIT(4), .VEC_OPC(8'd253), .VEC_OVF(8'd254)) dut4 (
        .clk(clk), .reset(reset), .OpCode(op), .funct(fn), .Zero(zero), .Overflow(ovf),
        .PCWrite(pc_write[1]), .MemCtrl(mem_ctrl[1]), .IRWrite(ir_write[1]),
        .A_Control(a_ctl[1]), .B_Control(b_ctl[1]), .RegControl(reg_ctl[1]),
        .ALUOutControl(aluout_ctl[1]), .EPCWrite(epc_write[1]), .IorD(iord[1]),
        .ALUSrcA(src_a[1]), .ALUSrcB(src_b[1]), .ExcpCtrl(excp[1]), .RegDst(reg_dst[1]),
        .PCSource(pc_src[1]), .ALUControl(alu_ctl[1]), .DataSrc(data_src[1]), .estado(estado[1])
    );

    // Reference model: expected per-cycle control word for one whole instruction.
    obs_t exp_q[$];

    function automatic obs_t blank(input logic [6:0] st);
        obs_t r;
        r = '0;
        r.estado = st;
        return r;
    endfunction

    task automatic push_exception(input int mw, input logic [1:0] code, input logic [6:0] st);
        obs_t r;
        r = blank(st); r.epc_write = 1'b1; r.src_b = 2'b01; r.alu_ctl = 3'b010; r.excp = code;
        exp_q.push_back(r);
        for (int i = 0; i < mw; i++) begin
            r = blank(7'd14); r.iord = 2'b10; r.excp = code;
            exp_q.push_back(r);
        end
        r = blank(7'd14); r.iord = 2'b10; r.excp = code; r.pc_src = 3'b011; r.pc_write = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic build_trace(input int mw, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic v);
        obs_t r;
        logic trap;
        exp_q.delete();
        for (int i = 0; i < mw; i++) exp_q.push_back(blank(7'd0));
        r = blank(7'd0); r.ir_write = 1'b1; r.pc_write = 1'b1; r.src_b = 2'b01; r.alu_ctl = 3'b001;
        exp_q.push_back(r);
        r = blank(7'd1); r.a_ctl = 1'b1; r.b_ctl = 1'b1; r.aluout_ctl = 1'b1;
        r.src_b = 2'b11; r.alu_ctl = 3'b001;
        exp_q.push_back(r);
        if (o == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24)) begin
            trap = v && (f != 6'h24);
            r = blank(7'd2); r.src_a = 2'b01;
            r.alu_ctl = (f == 6'h20) ? 3'b001 : (f == 6'h22) ? 3'b010 : 3'b011;
            r.aluout_ctl = !trap;
            exp_q.push_back(r);
            if (trap) push_exception(mw, 2'b10, 7'd12);
            else begin
                r = blank(7'd3); r.reg_ctl = 1'b1; r.reg_dst = 3'b001;
                exp_q.push_back(r);
            end
        end else if (o == 6'h08 || o == 6'h09) begin
            trap = v && (o == 6'h08);
            r = blank(7'd4); r.src_a = 2'b01; r.src_b = 2'b10; r.alu_ctl = 3'b001; r.aluout_ctl = !trap;
            exp_q.push_back(r);
            if (trap) push_exception(mw, 2'b10, 7'd12);
            else begin
                r = blank(7'd5); r.reg_ctl = 1'b1;
                exp_q.push_back(r);
            end
        end else if (o == 6'h23 || o == 6'h2B) begin
            r = blank(7'd6); r.src_a = 2'b01; r.src_b = 2'b10; r.alu_ctl = 3'b001; r.aluout_ctl = 1'b1;
            exp_q.push_back(r);
            if (o == 6'h23) begin
                for (int i = 0; i <= mw; i++) begin
                    r = blank(7'd7); r.iord = 2'b01;
                    exp_q.push_back(r);
                end
                r = blank(7'd8); r.reg_ctl = 1'b1; r.data_src = 4'b0001;
                exp_q.push_back(r);
            end else begin
                r = blank(7'd9); r.iord = 2'b01; r.mem_ctrl = 1'b1;
                exp_q.push_back(r);
            end
        end else if (o == 6'h04 || o == 6'h05) begin
            r = blank(7'd10); r.src_a = 2'b01; r.alu_ctl = 3'b010; r.pc_src = 3'b001;
            r.pc_write = (o == 6'h04) ? z : !z;
            exp_q.push_back(r);
        end else if (o == 6'h02) begin
            r = blank(7'd11); r.pc_src = 3'b010; r.pc_write = 1'b1;
            exp_q.push_back(r);
        end else begin
            push_exception(mw, 2'b01, 7'd13);
        end
    endtask

    // Drives one instruction from its first FETCH cycle; ncyc>0 stops early (for mid-instruction reset).
    task automatic run_instr(input int mw, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input logic v, input string name, input int ncyc);
        int n;
        int sel;
        sel = (mw == 2) ? 0 : 1;
        build_trace(mw, o, f, z, v);
        n = (ncyc > 0 && ncyc < exp_q.size()) ? ncyc : exp_q.size();
        op = o; fn = f; zero = z; ovf = v;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (obs[sel] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s mw=%0d cyc=%0d op=%h fn=%h z=%0b ovf=%0b got=%h expected=%h",
                         name, mw, i, o, f, z, v, obs[sel], exp_q[i]);
            end
            @(posedge clk); #1;
        end
        if (ncyc == 0) begin
            #1;
            checks++;
            if (obs[sel] !== obs_t'('0)) begin
                failures++;
                $display("FAIL %s_refetch mw=%0d got=%h expected=%h", name, mw, obs[sel], obs_t'('0));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== obs_t'('0)) begin
                failures++;
                $display("FAIL reset_state inst=%0d got=%h expected=%h", k, obs[k], obs_t'('0));
            end
        end
        // LW up to the last LW_MEM cycle (3 fetch + decode + addr + 2 wait), then reset for 3 cycles.
        run_instr(2, 6'h23, 6'h00, 1'b0, 1'b0, "lw_pre_reset", 7);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (obs[0].reg_ctl !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_regwrite cyc=%0d got=%0b expected=0", k, obs[0].reg_ctl);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs[0] !== obs_t'('0)) begin
            failures++;
            $display("FAIL reset_mid_lw got=%h expected=%h", obs[0], obs_t'('0));
        end
        run_instr(2, 6'h00, 6'h20, 1'b0, 1'b0, "add_after_reset", 0);
    endtask

    task automatic test_add();
        run_instr(2, 6'h00, 6'h20, 1'b0, 1'b0, "add", 0);
        run_instr(2, 6'h00, 6'h22, 1'b0, 1'b0, "sub", 0);
        run_instr(2, 6'h00, 6'h24, 1'b0, 1'b1, "and_ovf_ignored", 0);
    endtask

    task automatic test_overflow();
        run_instr(2, 6'h00, 6'h20, 1'b0, 1'b1, "add_ovf", 0);
        run_instr(2, 6'h08, 6'h00, 1'b0, 1'b1, "addi_ovf", 0);
        run_instr(2, 6'h09, 6'h00, 1'b0, 1'b1, "addiu_no_trap", 0);
    endtask

    task automatic test_invalid();
        run_instr(2, 6'h3F, 6'h00, 1'b0, 1'b0, "opc_3f", 0);
        run_instr(2, 6'h00, 6'h21, 1'b0, 1'b0, "bad_funct", 0);
        run_instr(2, 6'h02, 6'h00, 1'b0, 1'b0, "jump", 0);
    endtask

    task automatic test_branch();
        run_instr(2, 6'h04, 6'h00, 1'b1, 1'b0, "beq_taken", 0);
        run_instr(2, 6'h04, 6'h00, 1'b0, 1'b0, "beq_not_taken", 0);
        run_instr(2, 6'h05, 6'h00, 1'b1, 1'b0, "bne_not_taken", 0);
        run_instr(2, 6'h05, 6'h00, 1'b0, 1'b0, "bne_taken", 0);
    endtask

    task automatic test_mem_wait4();
        run_instr(4, 6'h2B, 6'h00, 1'b0, 1'b0, "sw_w4", 0);
        run_instr(4, 6'h23, 6'h00, 1'b0, 1'b0, "lw_w4", 0);
        run_instr(4, 6'h3F, 6'h00, 1'b0, 1'b0, "opc_w4", 0);
    endtask

    // Back-to-back random instructions, mostly legal, with random Zero/Overflow.
    task automatic test_random(input int mw, input int count);
        logic [5:0] ops [10];
        logic [5:0] fns [3];
        logic [5:0] o, f;
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24};
        for (int i = 0; i < count; i++) begin
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 9)];
            f = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 2)];
            run_instr(mw, o, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_invalid();
        test_branch();
        do_reset();
        test_mem_wait4();
        test_random(4, 30);
        do_reset();
        test_random(2, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
